wb_arbiter: RTL
===============

// Module: wb_arbiter
// PURPOSE
//  Two-master to one-slave arbiter for the SoC's pipelined Wishbone bus. Lets a second
//  bus master (DMA / debug port) share the memory and IO bus with the CPU core; sits
//  between both masters and the address decoder. Round-robin grant held for a whole
//  cycle (cyc). Tracks outstanding requests, drops stray acks, aborts hung slaves.
// PARAMETERS
//  MAX_PENDING  7     max accepted-but-unacked requests per grant (1..15)
//  TIMEOUT      1024  cycles without ack while pending>0 before bus error (0 = disabled)
// PORTS
//  clk           in   1   system clock
//  reset         in   1   synchronous, active-high reset
//  i_mN_wb_cyc   in   1   master N (N=0 CPU, N=1 aux) cycle request
//  i_mN_wb_stb   in   1   master N strobe
//  i_mN_wb_we    in   1   master N write enable
//  i_mN_wb_addr  in   32  master N address
//  i_mN_data     in   32  master N write data
//  i_mN_width    in   2   master N access width (byte/half/word)
//  o_mN_wb_stall out  1   stall to master N
//  o_mN_wb_ack   out  1   ack to master N
//  o_mN_wb_err   out  1   one-cycle bus-error pulse to master N
//  o_mN_data     out  32  read data to master N
//  o_s_wb_cyc/stb/we/addr/data/width  out  1/1/1/32/32/2  to slave bus
//  i_s_wb_stall, i_s_wb_ack  in  1  from slave bus;  i_s_data  in  32  slave read data
// BEHAVIOUR
//  - Reset (sync): state IDLE, last_grant=1 (M0 wins first tie), pending=0, timer=0,
//    block0=block1=0. Outputs: o_s_* all 0, o_mN_wb_stall=1, ack/err=0, data=0.
//  - States: IDLE, GNT0, GNT1. Grant is registered: cyc in cycle t -> slave cyc at t+1.
//  - IDLE: eligible = cyc & ~blockN. Both eligible -> grant master != last_grant;
//    one eligible -> grant it; none -> stay. On grant, last_grant <= N.
//  - GNTn: o_s_cyc/stb/we/addr/data/width = master n's (combinational); o_mn_stall =
//    i_s_wb_stall; o_mn_ack = i_s_wb_ack; o_mn_data = i_s_data. Other master: stall=1,
//    ack=0, err=0, data=0. In IDLE all o_s_* = 0.
//  - Release: granted cyc low -> IDLE next cycle; slave cyc is low >=1 cycle between
//    owners (no back-to-back handover).
//  - pending: +1 on o_s_stb & ~i_s_wb_stall; -1 on i_s_wb_ack; both same cycle ->
//    unchanged. pending==MAX_PENDING -> o_s_stb forced 0, master stall forced 1.
//  - Stray ack (pending==0, or state IDLE): not forwarded, counter stays 0.
//  - Master drops cyc with pending>0: abort; pending cleared, state IDLE, later acks dropped.
//  - timer: counts while pending>0 and no ack; cleared on ack or pending==0. When
//    timer == TIMEOUT-1 and no ack in that cycle: o_mn_wb_err=1 for that one cycle,
//    pending<=0, state<=IDLE, blockn<=1. blockn clears when i_mn_wb_cyc seen low.
//  - Ack and timeout expiry same cycle: ack wins, no error.
//  - reset asserted mid-transfer: next edge state IDLE, o_s_cyc=0, counters cleared.
// TESTING
//  1. M0 only: cyc/stb, addr 0xb0000010, slave ack 1 cycle later -> o_s_cyc at t+1,
//     addr passes, o_m0_ack=1, o_m0_data=i_s_data, M1 stall=1 throughout.
//  2. M0,M1 raise cyc same cycle after reset -> GNT0; M0 drops cyc -> 1 idle cycle ->
//     GNT1; repeat -> alternates M0,M1,M0 (round-robin).
//  3. Slave stall=1 for 4 cycles under M1 -> o_m1_stall=1 for exactly those cycles,
//     no request lost; 3 pipelined stb -> pending 3, 3 acks -> 0 -> M1 may drop cyc.
//  4. MAX_PENDING=2, slave never acks until 5 stbs offered -> o_s_stb low and master
//     stall high once pending==2; acks resume -> remaining requests issue.
//  5. TIMEOUT=16, slave never acks -> o_m0_err pulse 16 cycles after last progress,
//     o_s_cyc low next cycle, M0 not regranted until it drops cyc; M1 granted meanwhile.
//  6. Ack in IDLE, and reset asserted with pending=3 -> no ack forwarded, state IDLE,
//     pending=0 after reset edge.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// One pipelined Wishbone link. "master" drives requests, "slave" answers them.
// The shared slave bus has no error line, so err only appears on the slave modport.
interface wb_arbiter_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  width;
    logic        stall;
    logic        ack;
    logic        err;
    logic [31:0] rdata;

    modport master (
        output cyc, stb, we, addr, wdata, width,
        input  stall, ack, rdata
    );

    modport slave (
        input  cyc, stb, we, addr, wdata, width,
        output stall, ack, err, rdata
    );
endinterface

// File: rtl/wb_arbiter.sv
// Two-master round-robin arbiter for a pipelined Wishbone bus. Grant is held for a whole
// cycle; outstanding requests are tracked, stray acks dropped, hung slaves timed out.
module wb_arbiter #(
    parameter int unsigned MAX_PENDING = 7,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic         clk,
    input  logic         reset,
    wb_arbiter_if.slave  m0_io,
    wb_arbiter_if.slave  m1_io,
    wb_arbiter_if.master s_io
);
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StGnt0 = 2'd1;
    localparam logic [1:0] StGnt1 = 2'd2;

    localparam int unsigned        TimerW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TimerW-1:0]  TimerLast = (TIMEOUT == 0) ? '0 : TimerW'(TIMEOUT - 1);
    localparam logic [3:0]         PendMax   = 4'(MAX_PENDING);

    logic [1:0]        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [3:0]        pending_q, pending_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              block0_q, block0_d;
    logic              block1_q, block1_d;

    logic gnt0, gnt1, owned, own_cyc, own_stb;
    logic full, accept, ack_ok, expire, elig0, elig1;

    always_comb begin
        gnt0    = (state_q == StGnt0);
        gnt1    = (state_q == StGnt1);
        owned   = gnt0 | gnt1;
        own_cyc = (gnt0 & m0_io.cyc) | (gnt1 & m1_io.cyc);
        own_stb = (gnt0 & m0_io.stb) | (gnt1 & m1_io.stb);
        full    = (pending_q == PendMax);
        accept  = own_cyc & own_stb & ~full & ~s_io.stall;
        // Acks with nothing outstanding are strays and never reach a master.
        ack_ok  = owned & s_io.ack & (pending_q != '0);
        expire  = (TIMEOUT != 0) & own_cyc & (pending_q != '0) & ~ack_ok &
                  (timer_q == TimerLast);
        elig0   = m0_io.cyc & ~block0_q;
        elig1   = m1_io.cyc & ~block1_q;
    end

    always_comb begin
        s_io.cyc   = own_cyc;
        s_io.stb   = own_cyc & own_stb & ~full;
        s_io.we    = gnt0 ? m0_io.we    : (gnt1 ? m1_io.we    : 1'b0);
        s_io.addr  = gnt0 ? m0_io.addr  : (gnt1 ? m1_io.addr  : '0);
        s_io.wdata = gnt0 ? m0_io.wdata : (gnt1 ? m1_io.wdata : '0);
        s_io.width = gnt0 ? m0_io.width : (gnt1 ? m1_io.width : '0);

        m0_io.stall = gnt0 ? (full | s_io.stall) : 1'b1;
        m0_io.ack   = gnt0 & ack_ok;
        m0_io.err   = gnt0 & expire;
        m0_io.rdata = gnt0 ? s_io.rdata : '0;
        m1_io.stall = gnt1 ? (full | s_io.stall) : 1'b1;
        m1_io.ack   = gnt1 & ack_ok;
        m1_io.err   = gnt1 & expire;
        m1_io.rdata = gnt1 ? s_io.rdata : '0;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        pending_d    = pending_q;
        timer_d      = '0;
        block0_d     = block0_q & m0_io.cyc;
        block1_d     = block1_q & m1_io.cyc;
        case (state_q)
            StIdle: begin
                // On a tie the master that was not served last wins.
                if (elig0 & (~elig1 | last_grant_q)) begin
                    state_d      = StGnt0;
                    last_grant_d = 1'b0;
                end else if (elig1) begin
                    state_d      = StGnt1;
                    last_grant_d = 1'b1;
                end
            end
            default: begin
                if (!own_cyc) begin
                    state_d   = StIdle;
                    pending_d = '0;
                end else if (expire) begin
                    state_d   = StIdle;
                    pending_d = '0;
                    block0_d  = block0_d | gnt0;
                    block1_d  = block1_d | gnt1;
                end else begin
                    pending_d = pending_q + 4'(accept) - 4'(ack_ok);
                    if ((pending_q != '0) && !ack_ok) begin
                        timer_d = timer_q + TimerW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            pending_q    <= '0;
            timer_q      <= '0;
            block0_q     <= 1'b0;
            block1_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            pending_q    <= pending_d;
            timer_q      <= timer_d;
            block0_q     <= block0_d;
            block1_q     <= block1_d;
        end
    end
endmodule
